corepwm_pwm_engine: RTL and testbench

Parametrised successor to the CorePWM output generator. It owns its own prescaler and period counter, and double-buffers the edge registers so that updates only take effect at a period boundary. It supports per-channel edge-compare or sigma-delta DAC mode, and can optionally drive complementary outputs with dead-time insertion. It sits between the APB register file and the pads.

---
 rtl/corepwm_pkg.sv | 18 +
 rtl/corepwm_deadtime.sv | 60 ++++++
 rtl/corepwm_pwm_engine.sv | 131 +++++++++++++
 tb/tb_corepwm_pwm_engine.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/corepwm_pkg.sv
// Shared types and constants for the CorePWM engine and its dead-time stage.
package corepwm_pkg;

  typedef enum logic [1:0] {
    ST_ON_L = 2'd0,
    ST_ON_H = 2'd1,
    ST_DEAD = 2'd2
  } dt_state_e;

  localparam logic      RST_LEVEL = 1'b0;
  localparam dt_state_e RST_STATE = ST_ON_L;

  // Bit offset of channel ch inside a packed per-channel field bus.
  function automatic int unsigned chan_lsb(input int unsigned ch, input int unsigned width);
    return ch * width;
  endfunction

endpackage

// File: rtl/corepwm_deadtime.sv
// Per-channel dead-time insertion: splits raw into non-overlapping high/low-side drives.
module corepwm_deadtime
  import corepwm_pkg::*;
#(
  parameter int unsigned DT_WIDTH = 4
) (
  input  logic                PCLK,
  input  logic                PRESETN,
  input  logic                enable,
  input  logic                raw,
  input  logic [DT_WIDTH-1:0] dead_time_reg,
  output logic                pwm_h,
  output logic                pwm_l
);

  dt_state_e           state_q, state_d, settled;
  logic [DT_WIDTH-1:0] cnt_q, cnt_d;
  logic                raw_prev_q, pwm_h_q, pwm_l_q;

  always_comb begin
    settled = raw ? ST_ON_H : ST_ON_L;
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      state_d = ST_ON_L;
      cnt_d   = '0;
    end else if (raw != raw_prev_q) begin
      // Any edge (including one inside DEAD) restarts the dead interval.
      if (dead_time_reg == '0) begin
        state_d = settled;
      end else begin
        state_d = ST_DEAD;
        cnt_d   = dead_time_reg - 1'b1;
      end
    end else if (state_q == ST_DEAD) begin
      if (cnt_q == '0) state_d = settled;
      else             cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      state_q    <= RST_STATE;
      cnt_q      <= '0;
      raw_prev_q <= RST_LEVEL;
      pwm_h_q    <= RST_LEVEL;
      pwm_l_q    <= RST_LEVEL;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      raw_prev_q <= raw;
      pwm_h_q    <= enable && (state_d == ST_ON_H);
      pwm_l_q    <= enable && (state_d == ST_ON_L);
    end
  end

  assign pwm_h = pwm_h_q;
  assign pwm_l = pwm_l_q;

endmodule

// File: rtl/corepwm_pwm_engine.sv
// CorePWM output engine: prescaler, period counter, shadowed edge/DAC channels.
// Define COREPWM_DEADTIME_EN to build dead-time insertion and complementary outputs.
module corepwm_pwm_engine
  import corepwm_pkg::*;
#(
  parameter int unsigned        PWM_NUM    = 8,
  parameter int unsigned        APB_DWIDTH = 8,
  parameter logic [PWM_NUM-1:0] DAC_MODE   = '0,
  parameter int unsigned        DT_WIDTH   = 4
) (
  input  logic                          PCLK,
  input  logic                          PRESETN,
  input  logic [APB_DWIDTH-1:0]         prescale_reg,
  input  logic [APB_DWIDTH-1:0]         period_reg,
  input  logic [PWM_NUM-1:0]            pwm_enable_reg,
  input  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_posedge_reg,
  input  logic [PWM_NUM*APB_DWIDTH-1:0] pwm_negedge_reg,
  input  logic                          shadow_update_en,
  input  logic [DT_WIDTH-1:0]           dead_time_reg,
  output logic [PWM_NUM-1:0]            PWM,
  output logic [PWM_NUM-1:0]            PWM_N,
  output logic [APB_DWIDTH-1:0]         period_cnt,
  output logic                          sync_pulse
);

  localparam int unsigned W = APB_DWIDTH;

  logic [W-1:0]       presc_q, presc_d, period_q, period_d;
  logic               sync_q, sync_d, period_end, shadow_load;
  logic [PWM_NUM-1:0] raw;

  // sync is registered from the predicted count so it stays 0 during reset.
  always_comb begin
    presc_d     = (presc_q >= prescale_reg) ? '0 : presc_q + 1'b1;
    sync_d      = (presc_d == prescale_reg);
    period_end  = sync_q && (period_q >= period_reg);
    period_d    = period_q;
    if (sync_q) period_d = period_end ? '0 : period_q + 1'b1;
    shadow_load = period_end || !shadow_update_en;
  end

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) begin
      presc_q  <= '0;
      period_q <= '0;
      sync_q   <= RST_LEVEL;
    end else begin
      presc_q  <= presc_d;
      period_q <= period_d;
      sync_q   <= sync_d;
    end
  end

  for (genvar z = 0; z < PWM_NUM; z++) begin : g_ch
    logic [W-1:0] neg_q;

    always_ff @(posedge PCLK or negedge PRESETN) begin
      if (!PRESETN)         neg_q <= '0;
      else if (shadow_load) neg_q <= pwm_negedge_reg[chan_lsb(z, W) +: W];
    end

    if (DAC_MODE[z]) begin : g_dac
      logic [W:0] acc_q;
      logic       unused_pos;
      assign unused_pos = ^pwm_posedge_reg[chan_lsb(z, W) +: W];

      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)               acc_q <= '0;
        else if (!pwm_enable_reg[z]) acc_q <= '0;
        else                        acc_q <= {1'b0, acc_q[W-1:0]} + {1'b0, neg_q};
      end
      assign raw[z] = acc_q[W];
    end else begin : g_edge
      logic [W-1:0] pos_q;
      logic         raw_q, raw_d;

      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN)         pos_q <= '0;
        else if (shadow_load) pos_q <= pwm_posedge_reg[chan_lsb(z, W) +: W];
      end

      always_comb begin
        raw_d = raw_q;
        if (!pwm_enable_reg[z]) begin
          raw_d = 1'b0;
        end else if (sync_q) begin
          if ((pos_q == period_q) && (neg_q == period_q)) raw_d = ~raw_q;
          else if (pos_q == period_q)                     raw_d = 1'b1;
          else if (neg_q == period_q)                     raw_d = 1'b0;
        end
      end

      always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) raw_q <= RST_LEVEL;
        else          raw_q <= raw_d;
      end
      assign raw[z] = raw_q;
    end
  end

`ifdef COREPWM_DEADTIME_EN
  for (genvar z = 0; z < PWM_NUM; z++) begin : g_dt
    corepwm_deadtime #(
      .DT_WIDTH(DT_WIDTH)
    ) u_deadtime (
      .PCLK         (PCLK),
      .PRESETN      (PRESETN),
      .enable       (pwm_enable_reg[z]),
      .raw          (raw[z]),
      .dead_time_reg(dead_time_reg),
      .pwm_h        (PWM[z]),
      .pwm_l        (PWM_N[z])
    );
  end
`else
  logic [PWM_NUM-1:0] pwm_q;
  logic               unused_dt;
  assign unused_dt = ^dead_time_reg;

  always_ff @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) pwm_q <= '0;
    else          pwm_q <= raw;
  end
  assign PWM   = pwm_q;
  assign PWM_N = '0;
`endif

  assign period_cnt = period_q;
  assign sync_pulse = sync_q;

endmodule

// File: tb/tb_corepwm_pwm_engine.sv
// Self-checking bench for corepwm_pwm_engine: edge channels, shadowing, DAC, dead time, reset.
module tb_corepwm_pwm_engine;

  localparam int unsigned N = 8;
  localparam int unsigned W = 8;

  logic           PCLK = 1'b0;
  logic           PRESETN = 1'b0;
  logic [W-1:0]   prescale_reg, period_reg;
  logic [N-1:0]   pwm_enable_reg;
  logic [N*W-1:0] pwm_posedge_reg, pwm_negedge_reg;
  logic           shadow_update_en;
  logic [3:0]     dead_time_reg;
  logic [N-1:0]   PWM, PWM_N;
  logic [W-1:0]   period_cnt;
  logic           sync_pulse;

  logic [W-1:0]   dac_level;
  logic           dac_en;
  logic           dac_pwm, dac_pwm_n, dac_sync;
  logic [W-1:0]   dac_pcnt;

  int checks = 0;
  int errors = 0;
  int cyc = -1;
  bit run_mon = 1'b0;

  typedef struct {
    int           cyc;
    logic [1:0]   pwm;
    logic [W-1:0] pcnt;
    logic         sync;
    logic         shadow;
    logic [W-1:0] neg0;
  } vec_t;

  vec_t tbl[19];
  vec_t exp_q[$];

  always #5 PCLK = ~PCLK;

  always @(posedge PCLK or negedge PRESETN) begin
    if (!PRESETN) cyc <= -1;
    else          cyc <= cyc + 1;
  end

  corepwm_pwm_engine #(
    .PWM_NUM   (N),
    .APB_DWIDTH(W),
    .DAC_MODE  ('0),
    .DT_WIDTH  (4)
  ) dut (
    .PCLK            (PCLK),
    .PRESETN         (PRESETN),
    .prescale_reg    (prescale_reg),
    .period_reg      (period_reg),
    .pwm_enable_reg  (pwm_enable_reg),
    .pwm_posedge_reg (pwm_posedge_reg),
    .pwm_negedge_reg (pwm_negedge_reg),
    .shadow_update_en(shadow_update_en),
    .dead_time_reg   (dead_time_reg),
    .PWM             (PWM),
    .PWM_N           (PWM_N),
    .period_cnt      (period_cnt),
    .sync_pulse      (sync_pulse)
  );

  corepwm_pwm_engine #(
    .PWM_NUM   (1),
    .APB_DWIDTH(W),
    .DAC_MODE  (1'b1),
    .DT_WIDTH  (4)
  ) u_dac (
    .PCLK            (PCLK),
    .PRESETN         (PRESETN),
    .prescale_reg    (8'd0),
    .period_reg      (8'd0),
    .pwm_enable_reg  (dac_en),
    .pwm_posedge_reg (8'd0),
    .pwm_negedge_reg (dac_level),
    .shadow_update_en(1'b0),
    .dead_time_reg   (4'd0),
    .PWM             (dac_pwm),
    .PWM_N           (dac_pwm_n),
    .period_cnt      (dac_pcnt),
    .sync_pulse      (dac_sync)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int k);
    int guard = 0;
    while (cyc < k && guard < 5000) begin
      @(negedge PCLK);
      guard++;
    end
    if (cyc != k) begin
      checks++;
      errors++;
      $display("FAIL wait_cyc got=%0d expected=%0d", cyc, k);
    end
  endtask

  // Mutual exclusion of the two outputs, and PWM_N tied low without dead-time support.
  always @(negedge PCLK) begin
    if (PRESETN && run_mon) begin
      checks++;
      if ((PWM & PWM_N) != '0) begin
        errors++;
        $display("FAIL overlap PWM=%0h PWM_N=%0h expected no common bits", PWM, PWM_N);
      end
`ifndef COREPWM_DEADTIME_EN
      checks++;
      if (PWM_N != '0) begin
        errors++;
        $display("FAIL pwm_n_tied got=%0h expected=0", PWM_N);
      end
`endif
    end
  end

  initial begin
    vec_t v;
    vec_t got;
    logic [1:0] exp_n;
    int cnt0, cnt1, cntd, b;

    // cycle, PWM[1:0], period_cnt, sync, then inputs driven after the check
    tbl[0]  = '{0,   2'b00, 8'd0, 1'b1, 1'b0, 8'd6};
    tbl[1]  = '{1,   2'b00, 8'd1, 1'b0, 1'b0, 8'd6};
    tbl[2]  = '{5,   2'b00, 8'd3, 1'b0, 1'b0, 8'd6};
    tbl[3]  = '{6,   2'b01, 8'd3, 1'b1, 1'b0, 8'd6};
    tbl[4]  = '{11,  2'b01, 8'd6, 1'b0, 1'b0, 8'd6};
    tbl[5]  = '{12,  2'b11, 8'd6, 1'b1, 1'b0, 8'd6};
    tbl[6]  = '{13,  2'b11, 8'd7, 1'b0, 1'b0, 8'd6};
    tbl[7]  = '{14,  2'b10, 8'd7, 1'b1, 1'b0, 8'd6};
    tbl[8]  = '{19,  2'b10, 8'd0, 1'b0, 1'b0, 8'd6};
    tbl[9]  = '{26,  2'b11, 8'd3, 1'b1, 1'b0, 8'd6};
    tbl[10] = '{32,  2'b01, 8'd6, 1'b1, 1'b0, 8'd6};
    tbl[11] = '{34,  2'b00, 8'd7, 1'b1, 1'b0, 8'd6};
    tbl[12] = '{40,  2'b00, 8'd0, 1'b1, 1'b1, 8'd6};
    tbl[13] = '{52,  2'b11, 8'd6, 1'b1, 1'b1, 8'd6};
    tbl[14] = '{85,  2'b00, 8'd3, 1'b0, 1'b1, 8'd4};
    tbl[15] = '{93,  2'b11, 8'd7, 1'b0, 1'b1, 8'd4};
    tbl[16] = '{94,  2'b10, 8'd7, 1'b1, 1'b1, 8'd4};
    tbl[17] = '{109, 2'b11, 8'd5, 1'b0, 1'b1, 8'd4};
    tbl[18] = '{110, 2'b10, 8'd5, 1'b1, 1'b1, 8'd4};

    prescale_reg     = 8'd1;
    period_reg       = 8'd9;
    pwm_enable_reg   = 8'b0000_0011;
    pwm_posedge_reg  = '0;
    pwm_negedge_reg  = '0;
    pwm_posedge_reg[7:0]  = 8'd2;
    pwm_negedge_reg[7:0]  = 8'd6;
    pwm_posedge_reg[15:8] = 8'd5;
    pwm_negedge_reg[15:8] = 8'd5;
    shadow_update_en = 1'b0;
    dead_time_reg    = 4'd0;
    dac_level        = 8'd64;
    dac_en           = 1'b1;

    repeat (3) @(negedge PCLK);
    #1;
    check("reset_pwm", 32'(PWM), 32'd0);
    check("reset_pwm_n", 32'(PWM_N), 32'd0);
    check("reset_pcnt", 32'(period_cnt), 32'd0);
    check("reset_sync", 32'(sync_pulse), 32'd0);
    @(negedge PCLK);
    PRESETN = 1'b1;
    run_mon = 1'b1;

    for (int i = 0; i < 19; i++) begin
      v = tbl[i];
      exp_q.push_back(v);
      wait_cyc(v.cyc);
      got = exp_q.pop_front();
`ifdef COREPWM_DEADTIME_EN
      exp_n = ~got.pwm;
`else
      exp_n = 2'b00;
`endif
      check($sformatf("pwm@%0d", got.cyc), 32'(PWM[1:0]), 32'(got.pwm));
      check($sformatf("pwm_n@%0d", got.cyc), 32'(PWM_N[1:0]), 32'(exp_n));
      check($sformatf("pcnt@%0d", got.cyc), 32'(period_cnt), 32'(got.pcnt));
      check($sformatf("sync@%0d", got.cyc), 32'(sync_pulse), 32'(got.sync));
      shadow_update_en     = got.shadow;
      pwm_negedge_reg[7:0] = got.neg0;
    end

    // 256-cycle window: DAC duty and edge-channel duty counts.
    wait_cyc(120);
    cnt0 = 0; cnt1 = 0; cntd = 0;
    for (int i = 0; i < 256; i++) begin
      cnt0 += int'(PWM[0]);
      cnt1 += int'(PWM[1]);
      cntd += int'(dac_pwm);
      @(negedge PCLK);
    end
    check("dac_level64_count", 32'(cntd), 32'd64);
    check("ch0_neg4_count", 32'(cnt0), 32'd52);
    check("ch1_toggle_count", 32'(cnt1), 32'd124);

    dac_level = 8'd0;
    repeat (4) @(negedge PCLK);
    cntd = 0;
    for (int i = 0; i < 256; i++) begin
      cntd += int'(dac_pwm);
      @(negedge PCLK);
    end
    check("dac_level0_count", 32'(cntd), 32'd0);

    b = ((cyc / 20) + 3) * 20;
    wait_cyc(b - 40);
    pwm_negedge_reg[7:0] = 8'd6;
`ifdef COREPWM_DEADTIME_EN
    dead_time_reg = 4'd3;
    wait_cyc(b + 5);  check("dt3_pre",  32'({PWM[0], PWM_N[0]}), 32'b01);
    wait_cyc(b + 6);  check("dt3_r6",   32'({PWM[0], PWM_N[0]}), 32'b00);
    wait_cyc(b + 8);  check("dt3_r8",   32'({PWM[0], PWM_N[0]}), 32'b00);
    wait_cyc(b + 9);  check("dt3_hi9",  32'({PWM[0], PWM_N[0]}), 32'b10);
    wait_cyc(b + 13); check("dt3_hi13", 32'({PWM[0], PWM_N[0]}), 32'b10);
    wait_cyc(b + 14); check("dt3_f14",  32'({PWM[0], PWM_N[0]}), 32'b00);
    wait_cyc(b + 16); check("dt3_f16",  32'({PWM[0], PWM_N[0]}), 32'b00);
    wait_cyc(b + 17); check("dt3_lo17", 32'({PWM[0], PWM_N[0]}), 32'b01);
    wait_cyc(b + 20);
    dead_time_reg = 4'd15;
    cnt0 = 0;
    for (int i = 0; i < 40; i++) begin
      cnt0 += int'(PWM[0]);
      @(negedge PCLK);
    end
    check("dt15_suppress_count", 32'(cnt0), 32'd0);
    check("dt15_pwm_n_low", 32'(PWM_N[0]), 32'd0);
`else
    wait_cyc(b + 5);  check("neg6_pre",  32'(PWM[0]), 32'd0);
    wait_cyc(b + 6);  check("neg6_rise", 32'(PWM[0]), 32'd1);
    wait_cyc(b + 13); check("neg6_high", 32'(PWM[0]), 32'd1);
    wait_cyc(b + 14); check("neg6_fall", 32'(PWM[0]), 32'd0);
`endif

    // Asynchronous reset in the middle of a high pulse.
    wait_cyc(b + 67);
    run_mon = 1'b0;
    PRESETN = 1'b0;
    #1;
    check("midreset_pwm", 32'(PWM), 32'd0);
    check("midreset_pwm_n", 32'(PWM_N), 32'd0);
    check("midreset_pcnt", 32'(period_cnt), 32'd0);
    check("midreset_sync", 32'(sync_pulse), 32'd0);
    repeat (2) @(negedge PCLK);
    PRESETN = 1'b1;
    run_mon = 1'b1;
    wait_cyc(0); check("restart_pcnt0", 32'(period_cnt), 32'd0);
                 check("restart_sync0", 32'(sync_pulse), 32'd1);
    wait_cyc(1); check("restart_pcnt1", 32'(period_cnt), 32'd1);
                 check("restart_sync1", 32'(sync_pulse), 32'd0);
    wait_cyc(2); check("restart_sync2", 32'(sync_pulse), 32'd1);

    run_mon = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
